usbfs_pkt_tx: RTL

USB full-speed packet transmitter: serialises one packet per request (SYNC, PID, optional payload with CRC, EOP) onto USB d+/d- with NRZI encoding and bit stuffing. It runs from the 48MHz clock with an internally generated 12MHz bit timebase. It sits between the device transactor and the pad output-enable mux, and is the transmit counterpart of the full-speed packet receiver.

---
 rtl/usbfs_pkt_tx.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/usbfs_pkt_tx.sv
// USB full-speed packet transmitter: SYNC, PID, optional payload+CRC16 (or token+CRC5), EOP, NRZI with bit stuffing.
// Token packets (ADDR/ENDP + CRC5) are built only when USBFS_PKT_TX_TOKEN_EN is defined.
module usbfs_pkt_tx #(
  parameter int MAX_PKT = 8
) (
  input  logic                     i_clk_48MHz,
  input  logic                     i_rst_n,
  input  logic                     i_start,
  input  logic [3:0]               i_pid,
  input  logic [8*MAX_PKT-1:0]     i_data,
  input  logic [$clog2(MAX_PKT):0] i_data_nBytes,
`ifdef USBFS_PKT_TX_TOKEN_EN
  input  logic [6:0]               i_addr,
  input  logic [3:0]               i_endp,
`endif
  output logic                     o_ready,
  output logic                     o_done,
  output logic                     o_dp,
  output logic                     o_dn,
  output logic                     o_oe
);
  localparam int NBW = $clog2(MAX_PKT) + 1;

  typedef enum logic [3:0] {
    IDLE, SYNC, PID, DATA, CRC16, TOKEN, CRC5, EOP_SE0, EOP_J
  } stateType;

  stateType             state;
  logic [1:0]           phase;
  logic [3:0]           bitCnt;
  logic [2:0]           ones;
  logic [15:0]          crc16;
  logic [3:0]           pidReg;
  logic [8*MAX_PKT-1:0] dataReg;
  logic [NBW-1:0]       bytesLeft;
  logic [NBW-1:0]       nBytesClamped;
  logic [7:0]           pidByte;
  logic                 txBit;
`ifdef USBFS_PKT_TX_TOKEN_EN
  logic [15:0]          tokenReg;

  // Whole 16-bit token body, LSB first on the wire: ADDR, ENDP, then inverted CRC5 msb-first.
  function automatic logic [15:0] tokenWord(input logic [6:0] addr, input logic [3:0] endp);
    logic [10:0] field;
    logic [4:0]  crc;
    logic        fb;
    field = {endp, addr};
    crc   = 5'h1F;
    for (int i = 0; i < 11; i++) begin
      fb  = field[i] ^ crc[4];
      crc = {crc[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
    end
    return {~crc[0], ~crc[1], ~crc[2], ~crc[3], ~crc[4], field};
  endfunction
`endif

  assign nBytesClamped = (i_data_nBytes > NBW'(MAX_PKT)) ? NBW'(MAX_PKT) : i_data_nBytes;
  assign pidByte       = {~pidReg, pidReg};

  // State/bitCnt always name the next bit to be placed on the line.
  always_comb begin
    txBit = 1'b0;
    case (state)
      SYNC:    txBit = (bitCnt == 4'd7);
      PID:     txBit = pidByte[bitCnt[2:0]];
      DATA:    txBit = dataReg[0];
      CRC16:   txBit = ~crc16[4'd15 - bitCnt];
`ifdef USBFS_PKT_TX_TOKEN_EN
      TOKEN,
      CRC5:    txBit = tokenReg[0];
`endif
      default: txBit = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk_48MHz or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      phase     <= 2'd0;
      bitCnt    <= 4'd0;
      ones      <= 3'd0;
      crc16     <= 16'hFFFF;
      pidReg    <= 4'd0;
      dataReg   <= '0;
      bytesLeft <= '0;
`ifdef USBFS_PKT_TX_TOKEN_EN
      tokenReg  <= 16'd0;
`endif
      o_dp      <= 1'b1;
      o_dn      <= 1'b0;
      o_oe      <= 1'b0;
      o_ready   <= 1'b1;
      o_done    <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (state == IDLE) begin
        if (i_start) begin
          pidReg    <= i_pid;
          dataReg   <= i_data;
          bytesLeft <= nBytesClamped;
`ifdef USBFS_PKT_TX_TOKEN_EN
          tokenReg  <= tokenWord(i_addr, i_endp);
`endif
          crc16     <= 16'hFFFF;
          ones      <= 3'd0;
          phase     <= 2'd0;
          bitCnt    <= 4'd1;
          state     <= SYNC;
          o_dp      <= 1'b0;   // first SYNC bit is a 0, so the line goes straight to K
          o_dn      <= 1'b1;
          o_oe      <= 1'b1;
          o_ready   <= 1'b0;
        end
      end else begin
        phase <= phase + 2'd1;
        if (phase == 2'd3) begin
          if (ones == 3'd6) begin
            o_dp <= ~o_dp;
            o_dn <= ~o_dn;
            ones <= 3'd0;
          end else if (state == EOP_SE0) begin
            o_dp <= 1'b0;
            o_dn <= 1'b0;
            if (bitCnt == 4'd0) begin
              bitCnt <= 4'd1;
            end else begin
              bitCnt <= 4'd0;
              state  <= EOP_J;
            end
          end else if (state == EOP_J) begin
            if (bitCnt == 4'd0) begin
              o_dp   <= 1'b1;
              o_dn   <= 1'b0;
              bitCnt <= 4'd1;
            end else begin
              bitCnt  <= 4'd0;
              state   <= IDLE;
              o_oe    <= 1'b0;
              o_ready <= 1'b1;
              o_done  <= 1'b1;
            end
          end else begin
            if (!txBit) begin
              o_dp <= ~o_dp;
              o_dn <= ~o_dn;
            end
            ones <= txBit ? ones + 3'd1 : 3'd0;
            case (state)
              SYNC, PID: begin
                if (bitCnt == 4'd7) begin
                  bitCnt <= 4'd0;
                  if (state == SYNC) state <= PID;
                  else if (pidReg[1:0] == 2'b11) state <= (bytesLeft == '0) ? CRC16 : DATA;
`ifdef USBFS_PKT_TX_TOKEN_EN
                  else if (pidReg[1:0] == 2'b01) state <= TOKEN;
`endif
                  else state <= EOP_SE0;
                end else begin
                  bitCnt <= bitCnt + 4'd1;
                end
              end
              DATA: begin
                dataReg <= dataReg >> 1;
                crc16   <= {crc16[14:0], 1'b0} ^ ((dataReg[0] ^ crc16[15]) ? 16'h8005 : 16'h0000);
                if (bitCnt == 4'd7) begin
                  bitCnt    <= 4'd0;
                  bytesLeft <= bytesLeft - NBW'(1);
                  if (bytesLeft == NBW'(1)) state <= CRC16;
                end else begin
                  bitCnt <= bitCnt + 4'd1;
                end
              end
              CRC16: begin
                if (bitCnt == 4'd15) begin
                  bitCnt <= 4'd0;
                  state  <= EOP_SE0;
                end else begin
                  bitCnt <= bitCnt + 4'd1;
                end
              end
`ifdef USBFS_PKT_TX_TOKEN_EN
              TOKEN, CRC5: begin
                tokenReg <= tokenReg >> 1;
                if (state == TOKEN && bitCnt == 4'd10) begin
                  bitCnt <= 4'd0;
                  state  <= CRC5;
                end else if (state == CRC5 && bitCnt == 4'd4) begin
                  bitCnt <= 4'd0;
                  state  <= EOP_SE0;
                end else begin
                  bitCnt <= bitCnt + 4'd1;
                end
              end
`endif
              default: ;
            endcase
          end
        end
      end
    end
  end
endmodule
